// File: rtl/ir_rx_pkg.sv
// ir_rx_pkg
// Shared definitions for the IR frame receiver: default parameter values,
// the receiver FSM state encoding and a small majority-vote helper.
package ir_rx_pkg;

  localparam int OVERSAMPLE_DEF = 8;  // clock cycles per serial bit
  localparam int ADDR_W_DEF     = 8;  // address field width
  localparam int DATA_W_DEF     = 8;  // data (key) field width
  localparam int READY_W_DEF    = 2;  // Ready strobe length in cycles

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_OUTPUT = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ir_rx_sampler.sv
// ir_rx_sampler
// Front end of the IR receiver: synchronises the asynchronous serial line,
// detects falling edges, runs the per-bit phase counter and takes a 3-sample
// majority vote around the middle of every bit period.
//
// Ports
//   Clock        : receiver clock
//   Reset        : asynchronous active-low reset (already release-synchronised)
//   Serial       : raw serial line, idle high
//   restart      : clears the bit phase (asserted on the start-bit edge)
//   sample_valid : high for one cycle when a bit value is decided
//   sample_bit   : majority-voted bit value, meaningful with sample_valid
//   falling_edge : high for one cycle after the synchronised line falls
module ir_rx_sampler
  import ir_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Serial,
  input  logic restart,
  output logic sample_valid,
  output logic sample_bit,
  output logic falling_edge
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_LO   = PW'(H - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(H);
  localparam logic [PW-1:0] PH_HI   = PW'(H + 1);

  logic          sync1;
  logic          sync2;     // synchronised line
  logic          sync3;     // one further delayed copy for edge detection
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase;
  logic          samp_lo;
  logic          samp_mid;

  assign falling_edge = sync3 & ~sync2;

  // The cycle in which the edge is seen is itself phase 0, so the bit
  // boundaries line up with the synchronised line and the vote window
  // H-1..H+1 sits inside the bit even at OVERSAMPLE=4.
  assign phase = restart ? '0 : phase_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sync3    <= 1'b1;
      phase_q  <= '0;
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
    end else begin
      sync1   <= Serial;
      sync2   <= sync1;
      sync3   <= sync2;
      phase_q <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      if (phase == PH_LO)  samp_lo  <= sync2;
      if (phase == PH_MID) samp_mid <= sync2;
    end
  end

  // Third sample is the live synchronised value at H+1.
  assign sample_valid = (phase == PH_HI);
  assign sample_bit   = majority3(samp_lo, samp_mid, sync2);

endmodule

// File: rtl/ir_frame_receiver.sv
// ir_frame_receiver
// Receives an oversampled IR frame {addr, ~addr, data, ~data} (MSB first,
// preceded by a low start bit), checks the inverse fields and the optional
// address filter, and reports the result.
//
// Ports
//   Clock      : single receiver clock
//   Reset      : asynchronous active-low reset (release synchronised inside)
//   Serial     : asynchronous serial line, idle high
//   FilterEn   : when high only frames with addr == AddrFilter are accepted
//   AddrFilter : accepted address
//   Tecla      : data field of the last valid frame
//   Endereco   : address field of the last valid frame
//   Ready      : valid-frame strobe, READY_W cycles
//   Erro       : rejected-frame strobe, one cycle
//   state_dbg  : current FSM state
//
// Handshake: Ready and Erro are registered, mutually exclusive strobes with no
// back-pressure; Tecla/Endereco are stable while Ready is high and until the
// next valid frame.
module ir_frame_receiver
  import ir_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int READY_W    = READY_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Serial,
  input  logic              FilterEn,
  input  logic [ADDR_W-1:0] AddrFilter,
  output logic [DATA_W-1:0] Tecla,
  output logic [ADDR_W-1:0] Endereco,
  output logic              Ready,
  output logic              Erro,
  output rx_state_t         state_dbg
);

  localparam int F  = 2 * ADDR_W + 2 * DATA_W;
  localparam int BW = $clog2(F + 1);
  localparam int RW = $clog2(READY_W + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(F - 1);
  localparam logic [RW-1:0] RDY_LAST = RW'(READY_W - 1);

  // Reset: asserted asynchronously, released after two rising edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic sample_valid;
  logic sample_bit;
  logic falling_edge;
  logic restart;

  ir_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .Clock       (Clock),
    .Reset       (rst_n),
    .Serial      (Serial),
    .restart     (restart),
    .sample_valid(sample_valid),
    .sample_bit  (sample_bit),
    .falling_edge(falling_edge)
  );

  rx_state_t       state_q;
  rx_state_t       state_d;
  logic [BW-1:0]   bit_cnt_q;
  logic [BW-1:0]   bit_cnt_d;
  logic [RW-1:0]   rdy_cnt_q;
  logic [RW-1:0]   rdy_cnt_d;
  logic [F-1:0]    shreg;
  logic            shift_en;
  logic            load_out;
  logic            ready_d;
  logic            erro_d;
  logic            frame_ok;

  logic [ADDR_W-1:0] addr_f;
  logic [ADDR_W-1:0] inv_addr_f;
  logic [DATA_W-1:0] data_f;
  logic [DATA_W-1:0] inv_data_f;

  // Edges outside IDLE are ignored, so the phase only restarts from IDLE.
  assign restart = (state_q == ST_IDLE) && falling_edge;

  // First received bit ends up at the top of the shift register.
  assign addr_f     = shreg[F-1 -: ADDR_W];
  assign inv_addr_f = shreg[F-1-ADDR_W -: ADDR_W];
  assign data_f     = shreg[2*DATA_W-1 -: DATA_W];
  assign inv_data_f = shreg[DATA_W-1:0];

  assign frame_ok = (addr_f == ~inv_addr_f) &&
                    (data_f == ~inv_data_f) &&
                    (!FilterEn || (addr_f == AddrFilter));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rdy_cnt_d = rdy_cnt_q;
    shift_en  = 1'b0;
    load_out  = 1'b0;
    ready_d   = 1'b0;
    erro_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (falling_edge) state_d = ST_START;
      end
      ST_START: begin
        if (sample_valid) begin
          // A high majority means the edge was a glitch, not a start bit.
          if (!sample_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample_valid) begin
          shift_en = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = ST_CHECK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (frame_ok) begin
          load_out  = 1'b1;
          ready_d   = 1'b1;
          rdy_cnt_d = '0;
          state_d   = ST_OUTPUT;
        end else begin
          erro_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        // Ready is already high for this cycle; keep it for READY_W total.
        if (rdy_cnt_q == RDY_LAST) begin
          rdy_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rdy_cnt_d = rdy_cnt_q + 1'b1;
          ready_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rdy_cnt_q <= '0;
      shreg     <= '0;
      Tecla     <= '0;
      Endereco  <= '0;
      Ready     <= 1'b0;
      Erro      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rdy_cnt_q <= rdy_cnt_d;
      Ready     <= ready_d;
      Erro      <= erro_d;
      if (shift_en) shreg <= {shreg[F-2:0], sample_bit};
      if (load_out) begin
        Tecla    <= data_f;
        Endereco <= addr_f;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ir_frame_receiver.sv
module tb_ir_frame_receiver;
  import ir_rx_pkg::*;

  // Expected-queue entry: {is_err, strobe_cycle[31:0], endereco[15:0], tecla[15:0]}
  localparam int EW = 65;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        ser_a = 1'b1;
  logic        ser_b = 1'b1;
  logic        FilterEn = 1'b0;
  logic [7:0]  AddrFilter = 8'h00;
  logic [7:0]  tecla_a, end_a, end_b;
  logic [15:0] tecla_b;
  logic        ready_a, erro_a, ready_b, erro_b;
  rx_state_t   dbg_a, dbg_b;

  ir_frame_receiver dut_a (
    .Clock     (Clock),
    .Reset     (Reset),
    .Serial    (ser_a),
    .FilterEn  (FilterEn),
    .AddrFilter(AddrFilter),
    .Tecla     (tecla_a),
    .Endereco  (end_a),
    .Ready     (ready_a),
    .Erro      (erro_a),
    .state_dbg (dbg_a)
  );

  ir_frame_receiver #(
    .OVERSAMPLE(4),
    .ADDR_W    (8),
    .DATA_W    (16),
    .READY_W   (1)
  ) dut_b (
    .Clock     (Clock),
    .Reset     (Reset),
    .Serial    (ser_b),
    .FilterEn  (FilterEn),
    .AddrFilter(AddrFilter),
    .Tecla     (tecla_b),
    .Endereco  (end_b),
    .Ready     (ready_b),
    .Erro      (erro_b),
    .state_dbg (dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [15:0]   m_tec[2];
  logic [15:0]   m_end[2];
  logic          prev_rdy[2];
  int            run_len[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k, input logic rdy, input logic err,
                     input logic [15:0] tec, input logic [15:0] en);
    logic [EW-1:0] e;
    int rw;
    int qs;
    rw = (k == 0) ? 2 : 1;
    qs = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (rdy || err) check($sformatf("ready_erro_exclusive_%0d", k), {31'b0, rdy & err}, 32'd0);
    if ((rdy && !prev_rdy[k]) || err) begin
      if (qs == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe_%0d: got ready=%0b erro=%0b, expected none (cycle %0d)",
                 k, rdy, err, cyc);
      end else begin
        if (k == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("strobe_kind_%0d", k), {31'b0, err}, {31'b0, e[64]});
        check($sformatf("strobe_cycle_%0d", k), cyc, e[63:32]);
        check($sformatf("tecla_%0d", k), {16'b0, tec}, {16'b0, e[15:0]});
        check($sformatf("endereco_%0d", k), {16'b0, en}, {16'b0, e[31:16]});
      end
    end
    if (rdy) run_len[k]++;
    else if (prev_rdy[k]) begin
      check($sformatf("ready_width_%0d", k), run_len[k], rw);
      run_len[k] = 0;
    end
    prev_rdy[k] = rdy;
  endtask

  always @(negedge Clock) begin
    mon(0, ready_a, erro_a, {8'b0, tecla_a}, {8'b0, end_a});
    mon(1, ready_b, erro_b, tecla_b, {8'b0, end_b});
  end

  // ---------------- drivers ----------------
  task automatic tick(input int k, input logic v);
    @(posedge Clock);
    #1;
    if (k == 0) ser_a = v;
    else        ser_b = v;
  endtask

  // Sends start bit + {a, ia, d, id}. abort_bit>0 pulls Reset low at the start
  // of that data bit instead of finishing the frame. flip corrupts one of the
  // three voting samples of every data bit.
  task automatic send_frame(input int k, input logic [7:0] a, input logic [7:0] ia,
                            input logic [15:0] d, input logic [15:0] id,
                            input int abort_bit, input bit flip);
    logic bits[$];
    logic [15:0] mask;
    logic ok;
    int os, dw, h, nb, last_start;
    os   = (k == 0) ? 8 : 4;
    dw   = (k == 0) ? 8 : 16;
    h    = os / 2;
    mask = (k == 0) ? 16'h00FF : 16'hFFFF;
    for (int i = 7; i >= 0; i--) bits.push_back(a[i]);
    for (int i = 7; i >= 0; i--) bits.push_back(ia[i]);
    for (int i = dw - 1; i >= 0; i--) bits.push_back(d[i]);
    for (int i = dw - 1; i >= 0; i--) bits.push_back(id[i]);
    nb = bits.size();
    for (int c = 0; c < os; c++) tick(k, 1'b0);
    for (int j = 1; j <= nb; j++) begin
      int fp;
      if (j == abort_bit) begin
        Reset = 1'b0;
        m_tec[0] = '0; m_end[0] = '0; m_tec[1] = '0; m_end[1] = '0;
        repeat (3) tick(k, 1'b1);
        Reset = 1'b1;
        repeat (4 * os) tick(k, 1'b1);
        check("abort_tecla", {16'b0, (k == 0) ? {8'b0, tecla_a} : tecla_b}, 32'd0);
        check("abort_state", {29'b0, (k == 0) ? dbg_a : dbg_b}, {29'b0, ST_IDLE});
        return;
      end
      fp = h - 1 + int'($urandom_range(0, 2));
      for (int c = 0; c < os; c++) begin
        tick(k, (flip && c == fp) ? ~bits[j-1] : bits[j-1]);
        if (j == nb && c == 0) begin
          last_start = cyc;
          ok = ((a ^ ia) == 8'hFF) && (((d ^ id) & mask) == mask) &&
               (!FilterEn || a == AddrFilter);
          if (ok) begin
            m_tec[k] = d & mask;
            m_end[k] = {8'b0, a};
          end
          // Last bit decided at H+1 after 2-FF sync, strobes two cycles later.
          if (k == 0) exp_q0.push_back({~ok, 32'(last_start + h + 5), m_end[k], m_tec[k]});
          else        exp_q1.push_back({~ok, 32'(last_start + h + 5), m_end[k], m_tec[k]});
        end
      end
    end
    repeat (3 * os) tick(k, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  a, ia;
    logic [15:0] d, id;
    m_tec[0] = '0; m_tec[1] = '0; m_end[0] = '0; m_end[1] = '0;
    prev_rdy[0] = 1'b0; prev_rdy[1] = 1'b0; run_len[0] = 0; run_len[1] = 0;

    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    check("rst_tecla_a", {24'b0, tecla_a}, 32'd0);
    check("rst_endereco_a", {24'b0, end_a}, 32'd0);
    check("rst_ready_erro_a", {30'b0, ready_a, erro_a}, 32'd0);
    check("rst_state_a", {29'b0, dbg_a}, {29'b0, ST_IDLE});
    check("rst_tecla_b", {16'b0, tecla_b}, 32'd0);
    check("rst_ready_erro_b", {30'b0, ready_b, erro_b}, 32'd0);

    // Known-good frame, then same frame with broken data inverse.
    send_frame(0, 8'h00, 8'hFF, 16'h0045, 16'h00BA, 0, 1'b0);
    send_frame(0, 8'h00, 8'hFF, 16'h0045, 16'h00BB, 0, 1'b0);

    // Two-cycle glitch: START is entered, then abandoned without a strobe.
    tick(0, 1'b0); tick(0, 1'b0); tick(0, 1'b1); tick(0, 1'b1);
    check("glitch_start", {29'b0, dbg_a}, {29'b0, ST_START});
    repeat (20) tick(0, 1'b1);
    check("glitch_idle", {29'b0, dbg_a}, {29'b0, ST_IDLE});

    // Address filter: reject 0x20, accept 0x10.
    FilterEn = 1'b1; AddrFilter = 8'h10;
    send_frame(0, 8'h20, 8'hDF, 16'h0077, 16'h0088, 0, 1'b0);
    send_frame(0, 8'h10, 8'hEF, 16'h0033, 16'h00CC, 0, 1'b0);

    // Randomised frames with occasional broken inverses and filter settings.
    for (int n = 0; n < 14; n++) begin
      a = 8'($urandom); ia = ~a;
      d = {8'h00, 8'($urandom)}; id = {8'h00, ~d[7:0]};
      case ($urandom_range(0, 3))
        0: ia[$urandom_range(0, 7)] ^= 1'b1;
        1: id[$urandom_range(0, 7)] ^= 1'b1;
        default: ;
      endcase
      FilterEn   = 1'($urandom_range(0, 1));
      AddrFilter = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
      send_frame(0, a, ia, d, id, 0, 1'b0);
    end

    // Reset mid-frame, then a clean frame.
    FilterEn = 1'b0;
    send_frame(0, 8'h5A, 8'hA5, 16'h00E1, 16'h001E, 17, 1'b0);
    send_frame(0, 8'h03, 8'hFC, 16'h000C, 16'h00F3, 0, 1'b0);

    // Wide-data instance with one corrupted vote sample per bit.
    send_frame(1, 8'h12, 8'hED, 16'hA55A, 16'h5AA5, 0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      a = 8'($urandom); d = 16'($urandom);
      id = ~d;
      if (n == 2) id[$urandom_range(0, 15)] ^= 1'b1;
      send_frame(1, a, ~a, d, id, 0, 1'b1);
    end

    repeat (20) tick(0, 1'b1);
    check("drain_q0", exp_q0.size(), 32'd0);
    check("drain_q1", exp_q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
